// File: rtl/fifo_wr_ptr_full_ctrl.sv
// Write-side pointer / full-flag controller for the async FIFO.
// Optional overflow event counter port ovf_count is enabled by `define FIFO_WR_OVFL_CNT_EN.
module fifo_wr_ptr_full_ctrl #(
  parameter int FIFO_DEPTH  = 16,
  parameter int ADDR_WIDTH  = $clog2(FIFO_DEPTH),
  parameter int PTR_WIDTH   = ADDR_WIDTH + 1,
  parameter int AFULL_LEVEL = FIFO_DEPTH - 2
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  input  logic                  wr_en,
  input  logic [PTR_WIDTH-1:0]  rd_ptr_gray,
  output logic                  wr_mem_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [PTR_WIDTH-1:0]  wr_ptr_bin,
  output logic [PTR_WIDTH-1:0]  wr_ptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [PTR_WIDTH-1:0]  wr_level,
  output logic                  overflow
`ifdef FIFO_WR_OVFL_CNT_EN
  ,
  output logic [15:0]           ovf_count
`endif
);

  function automatic logic [PTR_WIDTH-1:0] gray2bin(input logic [PTR_WIDTH-1:0] g);
    logic [PTR_WIDTH-1:0] b;
    b[PTR_WIDTH-1] = g[PTR_WIDTH-1];
    for (int i = PTR_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [PTR_WIDTH-1:0] bin2gray(input logic [PTR_WIDTH-1:0] b);
    return b ^ {1'b0, b[PTR_WIDTH-1:1]};
  endfunction

  logic [PTR_WIDTH-1:0] wr_ptr_bin_q, wr_ptr_bin_d;
  logic [PTR_WIDTH-1:0] wr_ptr_gray_q, wr_ptr_gray_d;
  logic [PTR_WIDTH-1:0] rq1_q, rq2_q;
  logic [PTR_WIDTH-1:0] wr_level_q, wr_level_d;
  logic                 full_q, full_d;
  logic                 afull_q, afull_d;
  logic                 overflow_q, overflow_d;
  logic                 accept_s;
  logic                 ovf_evt_s;
  logic [PTR_WIDTH-1:0] rd_bin_sync_s;
  logic [PTR_WIDTH-1:0] full_cmp_s;

  // Next-state: the write is judged against the registered full flag only.
  always_comb begin
    accept_s      = wr_en & ~full_q;
    ovf_evt_s     = wr_en & full_q;
    wr_ptr_bin_d  = wr_ptr_bin_q + PTR_WIDTH'(accept_s);
    wr_ptr_gray_d = bin2gray(wr_ptr_bin_d);
    rd_bin_sync_s = gray2bin(rq2_q);
    // Full when write Gray equals read Gray with the two top bits inverted.
    full_cmp_s    = {~rq2_q[PTR_WIDTH-1:PTR_WIDTH-2], rq2_q[PTR_WIDTH-3:0]};
    full_d        = (wr_ptr_gray_d == full_cmp_s);
    wr_level_d    = wr_ptr_bin_d - rd_bin_sync_s;
    afull_d       = (wr_level_d >= PTR_WIDTH'(AFULL_LEVEL));
    overflow_d    = overflow_q | ovf_evt_s;
  end

  // Pointer, read-pointer synchroniser and flag registers; wr_rst release is expected wr_clk-synchronous.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wr_ptr_bin_q  <= {PTR_WIDTH{1'b0}};
      wr_ptr_gray_q <= {PTR_WIDTH{1'b0}};
      rq1_q         <= {PTR_WIDTH{1'b0}};
      rq2_q         <= {PTR_WIDTH{1'b0}};
      wr_level_q    <= {PTR_WIDTH{1'b0}};
      full_q        <= 1'b0;
      afull_q       <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wr_ptr_bin_q  <= wr_ptr_bin_d;
      wr_ptr_gray_q <= wr_ptr_gray_d;
      rq1_q         <= rd_ptr_gray;
      rq2_q         <= rq1_q;
      wr_level_q    <= wr_level_d;
      full_q        <= full_d;
      afull_q       <= afull_d;
      overflow_q    <= overflow_d;
    end
  end

`ifdef FIFO_WR_OVFL_CNT_EN
  logic [15:0] ovf_count_q;

  // Saturating count of dropped write attempts.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      ovf_count_q <= 16'h0000;
    end else if (ovf_evt_s && (ovf_count_q != 16'hFFFF)) begin
      ovf_count_q <= ovf_count_q + 16'h0001;
    end else begin
      ovf_count_q <= ovf_count_q;
    end
  end

  assign ovf_count = ovf_count_q;
`endif

  assign wr_mem_en   = accept_s;
  assign wr_addr     = wr_ptr_bin_q[ADDR_WIDTH-1:0];
  assign wr_ptr_bin  = wr_ptr_bin_q;
  assign wr_ptr_gray = wr_ptr_gray_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign wr_level    = wr_level_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_fifo_wr_ptr_full_ctrl.sv
// Directed bench for fifo_wr_ptr_full_ctrl (FIFO_DEPTH=16): vector table for fill,
// overflow and drain visibility, plus sequences for reset, wrap and reset mid-fill.
module tb_fifo_wr_ptr_full_ctrl;

  logic       wr_clk;
  logic       wr_rst;
  logic       wr_en;
  logic [4:0] rd_ptr_gray;
  logic       wr_mem_en;
  logic [3:0] wr_addr;
  logic [4:0] wr_ptr_bin;
  logic [4:0] wr_ptr_gray;
  logic       full;
  logic       almost_full;
  logic [4:0] wr_level;
  logic       overflow;
`ifdef FIFO_WR_OVFL_CNT_EN
  logic [15:0] ovf_count;
`endif

  int checks;
  int failures;

  fifo_wr_ptr_full_ctrl #(.FIFO_DEPTH(16)) dut (
    .wr_clk      (wr_clk),
    .wr_rst      (wr_rst),
    .wr_en       (wr_en),
    .rd_ptr_gray (rd_ptr_gray),
    .wr_mem_en   (wr_mem_en),
    .wr_addr     (wr_addr),
    .wr_ptr_bin  (wr_ptr_bin),
    .wr_ptr_gray (wr_ptr_gray),
    .full        (full),
    .almost_full (almost_full),
    .wr_level    (wr_level),
    .overflow    (overflow)
`ifdef FIFO_WR_OVFL_CNT_EN
    ,
    .ovf_count   (ovf_count)
`endif
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  typedef struct {
    logic       wr_en;
    logic [4:0] rd_gray;
    logic       mem_en;   // before the edge
    logic [3:0] addr;     // before the edge
    logic [4:0] bin;      // after the edge
    logic [4:0] gray;
    logic       full;
    logic       afull;
    logic [4:0] level;
    logic       ovf;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [4:0] rg, input logic me,
                              input logic [3:0] ad, input logic [4:0] b, input logic [4:0] g,
                              input logic f, input logic af, input logic [4:0] lv,
                              input logic ov);
    vec_t v;
    v.wr_en = we; v.rd_gray = rg; v.mem_en = me; v.addr = ad; v.bin = b; v.gray = g;
    v.full = f; v.afull = af; v.level = lv; v.ovf = ov;
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_bin"},   32'(wr_ptr_bin),  32'h0);
    chk({tag, "_gray"},  32'(wr_ptr_gray), 32'h0);
    chk({tag, "_full"},  32'(full),        32'h0);
    chk({tag, "_afull"}, 32'(almost_full), 32'h0);
    chk({tag, "_level"}, 32'(wr_level),    32'h0);
    chk({tag, "_ovf"},   32'(overflow),    32'h0);
    chk({tag, "_addr"},  32'(wr_addr),     32'h0);
`ifdef FIFO_WR_OVFL_CNT_EN
    chk({tag, "_ovfcnt"}, 32'(ovf_count),  32'h0);
`endif
  endtask

  task automatic pulse_reset();
    @(negedge wr_clk);
    wr_en = 1'b0;
    rd_ptr_gray = 5'd0;
    wr_rst = 1'b1;
    @(negedge wr_clk);
    wr_rst = 1'b0;
  endtask

  logic [4:0] model_bin;
  logic [4:0] lag1, lag2;
  logic [4:0] prev_gray;
  logic       wrap_seen;

  initial begin
    checks = 0;
    failures = 0;
    wr_rst = 1'b1;
    wr_en = 1'b0;
    rd_ptr_gray = 5'd0;

    // Fill: accepts 1..16
    vecs[0]  = mk(1'b1, 5'h00, 1'b1, 4'd0,  5'd1,  5'h01, 1'b0, 1'b0, 5'd1,  1'b0);
    vecs[1]  = mk(1'b1, 5'h00, 1'b1, 4'd1,  5'd2,  5'h03, 1'b0, 1'b0, 5'd2,  1'b0);
    vecs[2]  = mk(1'b1, 5'h00, 1'b1, 4'd2,  5'd3,  5'h02, 1'b0, 1'b0, 5'd3,  1'b0);
    vecs[3]  = mk(1'b1, 5'h00, 1'b1, 4'd3,  5'd4,  5'h06, 1'b0, 1'b0, 5'd4,  1'b0);
    vecs[4]  = mk(1'b1, 5'h00, 1'b1, 4'd4,  5'd5,  5'h07, 1'b0, 1'b0, 5'd5,  1'b0);
    vecs[5]  = mk(1'b1, 5'h00, 1'b1, 4'd5,  5'd6,  5'h05, 1'b0, 1'b0, 5'd6,  1'b0);
    vecs[6]  = mk(1'b1, 5'h00, 1'b1, 4'd6,  5'd7,  5'h04, 1'b0, 1'b0, 5'd7,  1'b0);
    vecs[7]  = mk(1'b1, 5'h00, 1'b1, 4'd7,  5'd8,  5'h0C, 1'b0, 1'b0, 5'd8,  1'b0);
    vecs[8]  = mk(1'b1, 5'h00, 1'b1, 4'd8,  5'd9,  5'h0D, 1'b0, 1'b0, 5'd9,  1'b0);
    vecs[9]  = mk(1'b1, 5'h00, 1'b1, 4'd9,  5'd10, 5'h0F, 1'b0, 1'b0, 5'd10, 1'b0);
    vecs[10] = mk(1'b1, 5'h00, 1'b1, 4'd10, 5'd11, 5'h0E, 1'b0, 1'b0, 5'd11, 1'b0);
    vecs[11] = mk(1'b1, 5'h00, 1'b1, 4'd11, 5'd12, 5'h0A, 1'b0, 1'b0, 5'd12, 1'b0);
    vecs[12] = mk(1'b1, 5'h00, 1'b1, 4'd12, 5'd13, 5'h0B, 1'b0, 1'b0, 5'd13, 1'b0);
    vecs[13] = mk(1'b1, 5'h00, 1'b1, 4'd13, 5'd14, 5'h09, 1'b0, 1'b1, 5'd14, 1'b0);
    vecs[14] = mk(1'b1, 5'h00, 1'b1, 4'd14, 5'd15, 5'h08, 1'b0, 1'b1, 5'd15, 1'b0);
    vecs[15] = mk(1'b1, 5'h00, 1'b1, 4'd15, 5'd16, 5'h18, 1'b1, 1'b1, 5'd16, 1'b0);
    // Overflow: 3 writes while full are dropped
    vecs[16] = mk(1'b1, 5'h00, 1'b0, 4'd0,  5'd16, 5'h18, 1'b1, 1'b1, 5'd16, 1'b1);
    vecs[17] = mk(1'b1, 5'h00, 1'b0, 4'd0,  5'd16, 5'h18, 1'b1, 1'b1, 5'd16, 1'b1);
    vecs[18] = mk(1'b1, 5'h00, 1'b0, 4'd0,  5'd16, 5'h18, 1'b1, 1'b1, 5'd16, 1'b1);
    // Drain visibility: read pointer Gray(4) shows up on the 3rd edge
    vecs[19] = mk(1'b0, 5'h06, 1'b0, 4'd0,  5'd16, 5'h18, 1'b1, 1'b1, 5'd16, 1'b1);
    vecs[20] = mk(1'b0, 5'h06, 1'b0, 4'd0,  5'd16, 5'h18, 1'b1, 1'b1, 5'd16, 1'b1);
    vecs[21] = mk(1'b0, 5'h06, 1'b0, 4'd0,  5'd16, 5'h18, 1'b0, 1'b0, 5'd12, 1'b1);

    // Reset state, then async assertion mid-clock after a few writes
    #1;
    check_all_zero("reset_init");
    @(negedge wr_clk);
    wr_rst = 1'b0;
    wr_en = 1'b1;
    repeat (3) @(negedge wr_clk);
    wr_en = 1'b0;
    chk("pre_rst_bin", 32'(wr_ptr_bin), 32'd3);
    #2;
    wr_rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge wr_clk);
    wr_rst = 1'b0;

    // Table: fill, overflow, drain
    for (int i = 0; i < 22; i++) begin
      @(negedge wr_clk);
      wr_en = vecs[i].wr_en;
      rd_ptr_gray = vecs[i].rd_gray;
      #1;
      chk($sformatf("v%0d_mem_en", i), 32'(wr_mem_en), 32'(vecs[i].mem_en));
      chk($sformatf("v%0d_addr", i),   32'(wr_addr),   32'(vecs[i].addr));
      @(posedge wr_clk);
      #1;
      chk($sformatf("v%0d_bin", i),   32'(wr_ptr_bin),  32'(vecs[i].bin));
      chk($sformatf("v%0d_gray", i),  32'(wr_ptr_gray), 32'(vecs[i].gray));
      chk($sformatf("v%0d_full", i),  32'(full),        32'(vecs[i].full));
      chk($sformatf("v%0d_afull", i), 32'(almost_full), 32'(vecs[i].afull));
      chk($sformatf("v%0d_level", i), 32'(wr_level),    32'(vecs[i].level));
      chk($sformatf("v%0d_ovf", i),   32'(overflow),    32'(vecs[i].ovf));
    end
`ifdef FIFO_WR_OVFL_CNT_EN
    chk("ovf_count", 32'(ovf_count), 32'd3);
`endif

    // Wrap: 40 writes, read pointer trails the write count by 2 cycles
    pulse_reset();
    model_bin = 5'd0;
    lag1 = 5'd0;
    lag2 = 5'd0;
    prev_gray = 5'd0;
    wrap_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      rd_ptr_gray = lag2 ^ {1'b0, lag2[4:1]};
      wr_en = 1'b1;
      @(posedge wr_clk);
      #1;
      lag2 = lag1;
      lag1 = model_bin;
      model_bin = model_bin + 5'd1;
      if (model_bin == 5'd0) wrap_seen = 1'b1;
      chk($sformatf("wrap%0d_full", i), 32'(full), 32'd0);
      chk($sformatf("wrap%0d_bin", i), 32'(wr_ptr_bin), 32'(model_bin));
      chk($sformatf("wrap%0d_gray_step", i), $countones(wr_ptr_gray ^ prev_gray), 32'd1);
      prev_gray = wr_ptr_gray;
      @(negedge wr_clk);
    end
    wr_en = 1'b0;
    chk("wrap_seen", 32'(wrap_seen), 32'd1);
    chk("wrap_final_bin", 32'(wr_ptr_bin), 32'd8);
    chk("wrap_final_gray", 32'(wr_ptr_gray), 32'h0C);

    // Reset mid-fill
    pulse_reset();
    wr_en = 1'b1;
    repeat (7) @(negedge wr_clk);
    wr_en = 1'b0;
    chk("midfill_bin", 32'(wr_ptr_bin), 32'd7);
    chk("midfill_level", 32'(wr_level), 32'd7);
    #2;
    wr_rst = 1'b1;
    #1;
    chk("midrst_bin", 32'(wr_ptr_bin), 32'd0);
    chk("midrst_level", 32'(wr_level), 32'd0);
    @(negedge wr_clk);
    wr_rst = 1'b0;
    wr_en = 1'b1;
    #1;
    chk("post_rst_addr", 32'(wr_addr), 32'd0);
    chk("post_rst_mem_en", 32'(wr_mem_en), 32'd1);
    @(posedge wr_clk);
    #1;
    chk("post_rst_bin", 32'(wr_ptr_bin), 32'd1);
    wr_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
